// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial RAM arbiter for icache block fills and dcache fills / write-backs.
// Build option `MEMCTRL_RR_EN: round-robin on simultaneous requests (default: fixed dcache priority).
module mem_arbiter (
    input  logic         clk,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         roll_back,
    input  logic         ic_miss,
    input  logic [27:0]  ic_miss_a,
    input  logic         dc_miss,
    input  logic [27:0]  dc_miss_a,
    input  logic         dc_rw,
    input  logic [127:0] dc_wdata,
    input  logic [7:0]   mem_din,
    output logic [31:0]  mem_a,
    output logic         mem_wr,
    output logic [7:0]   mem_dout,
    output logic         ic_in_en,
    output logic [27:0]  ic_ain,
    output logic [127:0] ic_dout,
    output logic         dc_in_en,
    output logic [27:0]  dc_ain,
    output logic [127:0] dc_dout,
    output logic         dc_w_done
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    state_e         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic           owner_dc_q, owner_dc_d;
    logic [27:0]    addr_q, addr_d;
    logic [127:0]   buf_q, buf_d;
    logic           ic_in_en_q, ic_in_en_d;
    logic           dc_in_en_q, dc_in_en_d;
    logic           dc_w_done_q, dc_w_done_d;
    logic [27:0]    ic_ain_q, ic_ain_d;
    logic [27:0]    dc_ain_q, dc_ain_d;
    logic [127:0]   ic_dout_q, ic_dout_d;
    logic [127:0]   dc_dout_q, dc_dout_d;
    logic           ic_req, dc_req, grant_ic, grant_dc;
    logic [3:0]     rd_byte;
    logic [127:0]   fill_blk;

`ifdef MEMCTRL_RR_EN
    logic           prio_dc_q, prio_dc_d;
`endif

    // A requester whose completion pulse is still high is finishing, not asking again.
    always_comb begin
        ic_req = ic_miss && !ic_in_en_q && !roll_back;
        dc_req = dc_miss && !dc_in_en_q && !dc_w_done_q && !(roll_back && dc_rw);
`ifdef MEMCTRL_RR_EN
        grant_dc = dc_req && (prio_dc_q || !ic_req);
`else
        grant_dc = dc_req;
`endif
        grant_ic = ic_req && !grant_dc;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_dc_d  = owner_dc_q;
        addr_d      = addr_q;
        buf_d       = buf_q;
        ic_in_en_d  = ic_in_en_q;
        dc_in_en_d  = dc_in_en_q;
        dc_w_done_d = dc_w_done_q;
        ic_ain_d    = ic_ain_q;
        dc_ain_d    = dc_ain_q;
        ic_dout_d   = ic_dout_q;
        dc_dout_d   = dc_dout_q;
`ifdef MEMCTRL_RR_EN
        prio_dc_d   = prio_dc_q;
`endif
        rd_byte  = cnt_q[3:0] - 4'd1;
        // The last byte arrives on the completing edge, so the fill merges it with the 15 already captured.
        fill_blk = {mem_din, buf_q[119:0]};

        if (rdy_in) begin
            ic_in_en_d  = 1'b0;
            dc_in_en_d  = 1'b0;
            dc_w_done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_dc || grant_ic) begin
                        owner_dc_d = grant_dc;
                        addr_d     = grant_dc ? dc_miss_a : ic_miss_a;
                        buf_d      = dc_wdata;
                        cnt_d      = '0;
                        state_d    = (grant_dc && !dc_rw) ? WRITE : READ;
`ifdef MEMCTRL_RR_EN
                        prio_dc_d  = grant_ic;
`endif
                    end
                end
                READ: begin
                    if (roll_back) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        if (cnt_q != 5'd0) buf_d[{rd_byte, 3'b000} +: 8] = mem_din;
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd16) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            if (owner_dc_q) begin
                                dc_in_en_d = 1'b1;
                                dc_ain_d   = addr_q;
                                dc_dout_d  = fill_blk;
                            end else begin
                                ic_in_en_d = 1'b1;
                                ic_ain_d   = addr_q;
                                ic_dout_d  = fill_blk;
                            end
                        end
                    end
                end
                WRITE: begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd15) begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        dc_w_done_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_dc_q  <= 1'b0;
            addr_q      <= '0;
            buf_q       <= '0;
            ic_in_en_q  <= 1'b0;
            dc_in_en_q  <= 1'b0;
            dc_w_done_q <= 1'b0;
            ic_ain_q    <= '0;
            dc_ain_q    <= '0;
            ic_dout_q   <= '0;
            dc_dout_q   <= '0;
`ifdef MEMCTRL_RR_EN
            prio_dc_q   <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_dc_q  <= owner_dc_d;
            addr_q      <= addr_d;
            buf_q       <= buf_d;
            ic_in_en_q  <= ic_in_en_d;
            dc_in_en_q  <= dc_in_en_d;
            dc_w_done_q <= dc_w_done_d;
            ic_ain_q    <= ic_ain_d;
            dc_ain_q    <= dc_ain_d;
            ic_dout_q   <= ic_dout_d;
            dc_dout_q   <= dc_dout_d;
`ifdef MEMCTRL_RR_EN
            prio_dc_q   <= prio_dc_d;
`endif
        end
    end

    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        if (state_q != IDLE) mem_a = {addr_q, cnt_q[3:0]};
        if (state_q == WRITE) mem_dout = buf_q[{cnt_q[3:0], 3'b000} +: 8];
    end

    assign mem_wr    = rdy_in && (state_q == WRITE);
    assign ic_in_en  = ic_in_en_q;
    assign ic_ain    = ic_ain_q;
    assign ic_dout   = ic_dout_q;
    assign dc_in_en  = dc_in_en_q;
    assign dc_ain    = dc_ain_q;
    assign dc_dout   = dc_dout_q;
    assign dc_w_done = dc_w_done_q;

endmodule
